// File: rtl/rx_block_fsm.sv
// rx_block_fsm
//   64b/66b receive block classifier and receive state machine. Each accepted
//   block is held for one valid cycle so it can be judged with the following
//   block as lookahead, which decides whether a terminate block is legitimate.
//   Legal blocks pass through unchanged. Illegal ones are replaced by the error
//   control block and counted.
//
// Ports
//   i_clock      clock
//   i_reset      synchronous, active-high reset
//   i_rf_enable  block enable; 0 clears everything like reset, every cycle
//   i_valid      qualifies i_data, one block per asserted cycle
//   i_data       66-bit coded block: [65:64] sync header, [63:56] block type
//   o_data       checked block, or the error control block
//   o_valid      one-cycle pulse qualifying o_data
//   o_rx_state   receive state after evaluating the block on o_data
//                (RX_INIT=0, RX_C=1, RX_D=2, RX_T=3, RX_E=4)
//   o_err_cnt    saturating count of error blocks emitted
//
// Only NB_DATA_CODED = 66 is meaningful; the field positions are fixed.

module rx_block_fsm #(
  parameter int NB_DATA_CODED = 66,
  parameter int NB_ERR_CNT    = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_rf_enable,
  input  logic                     i_valid,
  input  logic [NB_DATA_CODED-1:0] i_data,
  output logic [NB_DATA_CODED-1:0] o_data,
  output logic                     o_valid,
  output logic [2:0]               o_rx_state,
  output logic [NB_ERR_CNT-1:0]    o_err_cnt
);

  typedef enum logic [2:0] {
    RX_INIT = 3'd0,
    RX_C    = 3'd1,
    RX_D    = 3'd2,
    RX_T    = 3'd3,
    RX_E    = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    CLS_C = 3'd0,
    CLS_D = 3'd1,
    CLS_S = 3'd2,
    CLS_T = 3'd3,
    CLS_E = 3'd4
  } blk_cls_t;

  // Error control block: type 0x1E carrying eight /E/ (0x1E) characters.
  localparam logic [NB_DATA_CODED-1:0] ERR_BLOCK = 66'h2_1E_3C78F1E3C78F1E;

  // The eight terminate block types, one byte each.
  localparam logic [63:0] T_TYPES = 64'h87_99_AA_B4_CC_D2_E1_FF;

  // ---------------------------------------------------------------------------
  // Classification of the incoming block
  // ---------------------------------------------------------------------------
  logic [1:0] sync;
  logic [7:0] blk_type;
  logic [7:0] char_idle;
  logic [7:0] t_hit;
  blk_cls_t   in_cls;

  assign sync     = i_data[65:64];
  assign blk_type = i_data[63:56];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_char
      // 7-bit control characters of an all-control (0x1E) block.
      assign char_idle[gi] = (i_data[gi*7 +: 7] == 7'h00);
      assign t_hit[gi]     = (blk_type == T_TYPES[gi*8 +: 8]);
    end
  endgenerate

  always_comb begin
    in_cls = CLS_E;
    if (sync == 2'b01) begin
      in_cls = CLS_D;
    end else if (sync == 2'b10) begin
      if (blk_type == 8'h78) begin
        in_cls = CLS_S;
      end else if (|t_hit) begin
        in_cls = CLS_T;
      end else if ((blk_type == 8'h4B) || ((blk_type == 8'h1E) && (&char_idle))) begin
        in_cls = CLS_C;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                     clear;
  rx_state_t                state_reg,     state_next;
  logic [NB_DATA_CODED-1:0] hold_data_reg, hold_data_next;
  blk_cls_t                 hold_cls_reg,  hold_cls_next;
  logic                     primed_reg,    primed_next;
  logic [NB_DATA_CODED-1:0] data_reg,      data_next;
  logic                     valid_reg,     valid_next;
  logic [NB_ERR_CNT-1:0]    err_cnt_reg,   err_cnt_next;

  assign clear = i_reset | ~i_rf_enable;

  always_ff @(posedge i_clock) begin
    if (clear) begin
      state_reg     <= RX_INIT;
      hold_data_reg <= '0;
      hold_cls_reg  <= CLS_E;
      primed_reg    <= 1'b0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      hold_data_reg <= hold_data_next;
      hold_cls_reg  <= hold_cls_next;
      primed_reg    <= primed_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  logic next_ok;  // lookahead block may legally follow a terminate

  assign next_ok = (in_cls == CLS_S) || (in_cls == CLS_C);

  always_comb begin
    state_next     = state_reg;
    hold_data_next = hold_data_reg;
    hold_cls_next  = hold_cls_reg;
    primed_next    = primed_reg;
    data_next      = data_reg;
    valid_next     = 1'b0;
    err_cnt_next   = err_cnt_reg;

    if (i_valid) begin
      // Evaluate the held block only once there is a lookahead block for it.
      if (primed_reg) begin
        case (state_reg)
          RX_INIT, RX_C, RX_T: begin
            if (hold_cls_reg == CLS_C)      state_next = RX_C;
            else if (hold_cls_reg == CLS_S) state_next = RX_D;
            else                            state_next = RX_E;
          end
          RX_D: begin
            if (hold_cls_reg == CLS_D)                   state_next = RX_D;
            else if ((hold_cls_reg == CLS_T) && next_ok) state_next = RX_T;
            else                                         state_next = RX_E;
          end
          default: begin
            // RX_E: S is not a way out of the error state.
            if (hold_cls_reg == CLS_C)                   state_next = RX_C;
            else if (hold_cls_reg == CLS_D)              state_next = RX_D;
            else if ((hold_cls_reg == CLS_T) && next_ok) state_next = RX_T;
            else                                         state_next = RX_E;
          end
        endcase

        valid_next = 1'b1;
        if (state_next == RX_E) begin
          data_next = ERR_BLOCK;
          if (err_cnt_reg != '1) begin
            err_cnt_next = err_cnt_reg + 1'b1;
          end
        end else begin
          data_next = hold_data_reg;
        end
      end

      hold_data_next = i_data;
      hold_cls_next  = in_cls;
      primed_next    = 1'b1;
    end
  end

  assign o_data     = data_reg;
  assign o_valid    = valid_reg;
  assign o_rx_state = state_reg;
  assign o_err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_rx_block_fsm.sv
// tb_rx_block_fsm
//   Directed, table-driven bench for rx_block_fsm. Each table record holds an
//   input block and the outputs expected one clock after it is accepted.
//   Hand-written sequences cover reset/enable clear and counter saturation
//   (the counter is built 4 bits wide here so saturation is reachable).

module tb_rx_block_fsm;

  localparam int NB  = 66;
  localparam int NBC = 4;

  localparam logic [65:0] C    = 66'h2_1E_00000000000000;
  localparam logic [65:0] C6   = {2'b10, 8'h1E, 56'h00000000000006};
  localparam logic [65:0] C4B  = {2'b10, 8'h4B, 56'h0000000F000000};
  localparam logic [65:0] S    = {2'b10, 8'h78, 56'h11223344556677};
  localparam logic [65:0] T87  = {2'b10, 8'h87, 56'h00000000000000};
  localparam logic [65:0] TFF  = {2'b10, 8'hFF, 56'h00112233445566};
  localparam logic [65:0] D1   = {2'b01, 64'h0123456789ABCDEF};
  localparam logic [65:0] D2   = {2'b01, 64'hFEDCBA9876543210};
  localparam logic [65:0] D3   = {2'b01, 64'h55AA55AA00FF00FF};
  localparam logic [65:0] BAD  = {2'b00, 64'h0123456789ABCDEF};
  localparam logic [65:0] ERR  = 66'h2_1E_3C78F1E3C78F1E;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           vin;
  logic [NB-1:0]  din;
  logic [NB-1:0]  dout;
  logic           vout;
  logic [2:0]     st;
  logic [NBC-1:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [65:0] din;
    logic        exp_valid;
    logic [65:0] exp_data;
    logic [2:0]  exp_state;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t tbl[$];

  rx_block_fsm #(
    .NB_DATA_CODED(NB),
    .NB_ERR_CNT   (NBC)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_rf_enable(en),
    .i_valid    (vin),
    .i_data     (din),
    .o_data     (dout),
    .o_valid    (vout),
    .o_rx_state (st),
    .o_err_cnt  (cnt)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [65:0] d, input logic v, input logic [65:0] ed,
                     input logic [2:0] es, input logic [3:0] ec);
    vec_t r;
    r.din       = d;
    r.exp_valid = v;
    r.exp_data  = ed;
    r.exp_state = es;
    r.exp_cnt   = ec;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [65:0] act,
                     input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic v,
                         input logic [65:0] d, input logic [2:0] s, input logic [3:0] c);
    chk({tag, "_valid"}, idx, {65'd0, vout}, {65'd0, v});
    chk({tag, "_data"},  idx, dout, d);
    chk({tag, "_state"}, idx, {63'd0, st}, {63'd0, s});
    chk({tag, "_cnt"},   idx, {62'd0, cnt}, {62'd0, c});
  endtask

  task automatic send(input logic [65:0] d);
    vin = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    vin = 1'b0;
    din = '0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Apply table records [lo, hi), with 'gap' idle cycles after each one.
  task automatic run_range(input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) begin
      send(tbl[i].din);
      $display("vec %0d: in=%h -> valid=%b data=%h state=%0d cnt=%0d",
               i, tbl[i].din, vout, dout, st, cnt);
      chk_all("vec", i, tbl[i].exp_valid, tbl[i].exp_data, tbl[i].exp_state, tbl[i].exp_cnt);
      for (int g = 0; g < gap; g++) begin
        idle();
        chk_all("gap", i, 1'b0, tbl[i].exp_data, tbl[i].exp_state, tbl[i].exp_cnt);
      end
    end
  endtask

  int s1, s2, s3, s4, s5, s6a, s6b, s6c, s_end;

  initial begin
    // 1. idle stream
    s1 = tbl.size();
    add(C, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) add(C, 1, C, 1, 0);
    // 2. good frame
    s2 = tbl.size();
    add(C,   1, C,   1, 0);
    add(S,   1, C,   1, 0);
    add(D1,  1, S,   2, 0);
    add(D2,  1, D1,  2, 0);
    add(T87, 1, D2,  2, 0);
    add(C,   1, T87, 3, 0);
    add(C,   1, C,   1, 0);
    // 3. bad terminate (T followed by D)
    s3 = tbl.size();
    add(S,   1, C,   1, 0);
    add(D1,  1, S,   2, 0);
    add(TFF, 1, D1,  2, 0);
    add(D2,  1, ERR, 4, 1);
    add(T87, 1, D2,  2, 1);
    add(C,   1, T87, 3, 1);
    add(C,   1, C,   1, 1);
    // 4. bad sync header, non-idle 0x1E character, 0x4B ordered set
    s4 = tbl.size();
    add(S,   1, C,   1, 1);
    add(D1,  1, S,   2, 1);
    add(BAD, 1, D1,  2, 1);
    add(D2,  1, ERR, 4, 2);
    add(D3,  1, D2,  2, 2);
    add(T87, 1, D3,  2, 2);
    add(C,   1, T87, 3, 2);
    add(C6,  1, C,   1, 2);
    add(C4B, 1, ERR, 4, 3);
    add(C,   1, C4B, 1, 3);
    // 5. sparse valid, same frame as 2
    s5 = tbl.size();
    add(C,   1, C,   1, 3);
    add(S,   1, C,   1, 3);
    add(D1,  1, S,   2, 3);
    add(D2,  1, D1,  2, 3);
    add(T87, 1, D2,  2, 3);
    add(C,   1, T87, 3, 3);
    add(C,   1, C,   1, 3);
    // 6a. enter RX_D before reset
    s6a = tbl.size();
    add(S,  1, C, 1, 3);
    add(D1, 1, S, 2, 3);
    // 6b. after reset: prime, then RX_INIT->RX_E on D, then RX_D
    s6b = tbl.size();
    add(D1, 0, '0,  0, 0);
    add(D2, 1, ERR, 4, 1);
    add(C,  1, D2,  2, 1);
    // 6c. after enable-low clear: terminate validated by a following S
    s6c = tbl.size();
    add(C,   0, '0,  0, 0);
    add(S,   1, C,   1, 0);
    add(T87, 1, S,   2, 0);
    add(S,   1, T87, 3, 0);
    add(D1,  1, S,   2, 0);
    s_end = tbl.size();

    rst = 1'b1;
    en  = 1'b1;
    vin = 1'b0;
    din = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset", 0, 1'b0, '0, 3'd0, 4'd0);

    run_range(s1, s2, 0);
    run_range(s2, s3, 0);
    run_range(s3, s4, 0);
    run_range(s4, s5, 0);
    run_range(s5, s6a, 2);
    run_range(s6a, s6b, 0);

    // Reset mid-frame with a valid block present: reset wins.
    rst = 1'b1;
    vin = 1'b1;
    din = D3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vin = 1'b0;
    din = '0;
    $display("reset mid-frame -> valid=%b data=%h state=%0d cnt=%0d", vout, dout, st, cnt);
    chk_all("midrst", 0, 1'b0, '0, 3'd0, 4'd0);
    run_range(s6b, s6c, 0);

    // Enable low acts as a clear.
    en  = 1'b0;
    vin = 1'b1;
    din = D3;
    @(posedge clk);
    #1;
    en  = 1'b1;
    vin = 1'b0;
    din = '0;
    $display("enable low -> valid=%b data=%h state=%0d cnt=%0d", vout, dout, st, cnt);
    chk_all("enclr", 0, 1'b0, '0, 3'd0, 4'd0);
    run_range(s6c, s_end, 0);

    // Counter saturation: a long run of bad blocks after reset.
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send(BAD);
      $display("sat %0d: in=%h -> valid=%b data=%h state=%0d cnt=%0d",
               k, BAD, vout, dout, st, cnt);
      if (k == 0) chk_all("sat", k, 1'b0, '0, 3'd0, 4'd0);
      else        chk_all("sat", k, 1'b1, ERR, 3'd4, (k > 15) ? 4'd15 : 4'(k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_block_fsm.md
# rx_block_fsm

Receive 64b/66b block-type classifier and receive state machine per IEEE 802.3 Clause 82 (49.2.13 style). Sits directly downstream of the idle-insertion/clock-compensation stage and upstream of the 64b/66b decoder. It takes one 66-bit block per valid cycle and uses one block of lookahead to validate terminate blocks. It passes legal blocks unchanged and replaces illegal ones with the error control block. It exports the current RX state, so the clock-compensation stage can restrict idle insertion to the RX_C state.

## Interface
Parameters:
- NB_DATA_CODED, 66: coded block width; only 66 is supported.
- NB_ERR_CNT, 16: width of the saturating error-block counter.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_rf_enable  in  1  block enable; when 0, acts as a synchronous clear (same as reset) every cycle.
- i_valid  in  1  qualifies i_data; one block per asserted cycle.
- i_data  in  66  coded block; [65:64] sync header, [63:56] block type.
- o_data  out  66  checked block, or the error block.
- o_valid  out  1  qualifies o_data.
- o_rx_state  out  3  current state: RX_INIT=0, RX_C=1, RX_D=2, RX_T=3, RX_E=4.
- o_err_cnt  out  NB_ERR_CNT  number of error blocks emitted; saturates at all-ones.

## Operation
Block classification (combinational, applied to every block):
- D: sync 2'b01.
- S: sync 2'b10 and type 0x78.
- T: sync 2'b10 and type in {0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF}.
- C: sync 2'b10 and type 0x4B; or sync 2'b10, type 0x1E and all eight 7-bit control characters equal to 0x00.
- E: anything else, including sync 2'b00 or 2'b11, unknown types, and 0x1E blocks carrying any non-idle character.

Pipeline:
- Stage 1 (hold) stores the last accepted block and its class, plus a `primed` flag.
- When a new valid block arrives and `primed`=1, the held block (current) is evaluated using the incoming block as `next`.
- Evaluation updates the FSM and writes the output register.
- The incoming block then replaces the held block.
- The first valid after reset or enable-low only primes the pipeline and produces no output.

State transitions (evaluated on the current class, cur):
- RX_INIT and RX_C: C→RX_C; S→RX_D; otherwise →RX_E.
- RX_D: D→RX_D; T with next in {S, C}→RX_T; otherwise →RX_E.
- RX_T: C→RX_C; S→RX_D; otherwise →RX_E.
- RX_E: C→RX_C; D→RX_D; T with next in {S, C}→RX_T; otherwise →RX_E.

Output data:
- If the new state is RX_E, o_data = 66'h2_1E_3C78F1E3C78F1E (error control block: type 0x1E, eight 0x1E characters). In that case o_err_cnt increments by 1, saturating.
- Otherwise o_data is the current block, unmodified.
- o_rx_state shows the state after evaluation of the block currently presented on o_data.

## Timing
- Reset or i_rf_enable=0, sampled at a clock edge, gives on the next cycle:
  - o_data=0, o_valid=0, o_rx_state=RX_INIT, o_err_cnt=0;
  - primed=0 and the hold register cleared.
- Reset has priority over i_valid in the same cycle. Reset mid-frame discards the held block, with no output for it.
- Latency: the block accepted with valid number k appears on o_data in the cycle after valid number k+1 is accepted.
- o_valid is a registered pulse: it is 1 exactly one cycle after each accepted i_valid while primed.
- No backpressure: valid gaps of any length are allowed. While i_valid=0 the state, hold register and outputs are held, and o_valid=0.
- o_data and o_rx_state change only together with an o_valid pulse.
- The last block before a gap stays in the hold register until the next valid arrives; it is never flushed.
- The error counter never wraps: at 2^NB_ERR_CNT-1 it stays there.

## Test plan
1. **Idle stream.** Apply reset, then 6 consecutive C blocks 66'h2_1E_00000000000000.
   - Expect: 5 o_valid pulses, starting 2 cycles after the first valid.
   - Each o_data equals the input; o_rx_state=1; o_err_cnt=0.
2. **Good frame.** Send C, S(0x78), D, D, T(0x87), C, C.
   - Expect o_rx_state sequence 1, 2, 2, 2, 3, 1.
   - All data passes through unchanged; o_err_cnt=0.
3. **Bad terminate.** Send S, D, T(0xFF), D, C.
   - Expect the T output replaced with 66'h2_1E_3C78F1E3C78F1E and o_rx_state=4.
   - The following D output is passed through with o_rx_state=2; o_err_cnt=1.
4. **Bad sync header.** Inside a data run, send a sync 2'b00 block, then D, D.
   - Expect the error block with state 4, then recovery to state 2.
   - Also send a 0x1E block with one character 0x06: it gives the error block and o_err_cnt increments.
5. **Sparse valid.** Repeat scenario 2 with i_valid asserted once every 3 cycles.
   - Expect the same o_data and state sequence.
   - o_valid is high only in the cycle after each accepted valid.
6. **Reset mid-frame.** Assert i_reset in RX_D after S, D.
   - Expect state 0, o_valid=0, o_err_cnt=0 on the next cycle.
   - Then send D, D, C: expect an error block for the first D (RX_INIT→RX_E), then state 2.
